// File: rtl/spi_word_rx_pkg.sv
// Shared definitions for the SPI word receiver: default word width,
// synchronizer depth and the frame FSM state encoding.
package spi_pkg;

   localparam int WORD_W_DEFAULT = 16;
   localparam int SYNC_STAGES    = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/spi_word_rx_sync_2ff.sv
// Single-bit synchronizer bringing an asynchronous pin into the clk domain.
// Depth is taken from spi_pkg::SYNC_STAGES.
module sync_2ff
   import spi_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   // Shift the pin value through the synchronizer chain
   always_ff @(posedge clk) begin
      if (reset) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_word_rx.sv
// SPI slave receive path: synchronizes sck/sdi/cs, deserializes MSB-first
// words and buffers them in a small FIFO with a valid/ready output.
// Optional feature macro SPI_RX_STATS_EN adds saturating 8-bit counters
// err_count (frame errors) and ovf_count (FIFO overflows).
module spi_word_rx
   import spi_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEFAULT,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              sdi,
   input  logic              cs,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              frame_err,
   output logic              overflow,
   output logic              busy
`ifdef SPI_RX_STATS_EN
   ,
   output logic [7:0]        err_count,
   output logic [7:0]        ovf_count
`endif
);

   localparam int CW = $clog2(WORD_W);
   localparam int AW = $clog2(DEPTH);

   // ---------------------------------------------------------------
   // Stage 0/1: pin synchronization
   // ---------------------------------------------------------------
   logic sck_s;
   logic sdi_s;
   logic cs_s;

   sync_2ff u_sync_sck (
      .clk   (clk),
      .reset (reset),
      .d     (sck),
      .q     (sck_s)
   );

   sync_2ff u_sync_sdi (
      .clk   (clk),
      .reset (reset),
      .d     (sdi),
      .q     (sdi_s)
   );

   sync_2ff u_sync_cs (
      .clk   (clk),
      .reset (reset),
      .d     (cs),
      .q     (cs_s)
   );

   assign busy = cs_s;

   // ---------------------------------------------------------------
   // Stage 2: sck edge detect, shift register and frame FSM
   // ---------------------------------------------------------------
   logic              sck_q;
   logic              rise;
   logic              last_bit;
   logic [WORD_W-1:0] shift_reg;
   logic [CW-1:0]     bit_cnt;
   logic              push_p;
   state_t            state;

   // Delayed copy of synchronized sck for rising-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q <= 1'b0;
      end else begin
         sck_q <= sck_s;
      end
   end

   // Rises outside a frame (cs_s low) never count
   assign rise     = sck_s && !sck_q && cs_s;
   assign last_bit = (bit_cnt == CW'(WORD_W - 1));

   // Frame FSM, bit counter and deserializer; push_p requests a FIFO write
   // of the completed word held in shift_reg on the following edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         push_p    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         push_p    <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            IDLE: begin
               if (cs_s) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!cs_s) begin
                  // Partial word is dropped; only the counter needs clearing
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  frame_err <= (bit_cnt != '0);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // rise implies cs_s, so it never coincides with the SHIFT exit
         if (rise) begin
            shift_reg <= {shift_reg[WORD_W-2:0], sdi_s};
            if (last_bit) begin
               bit_cnt <= '0;
               push_p  <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 3: FIFO write / read
   // ---------------------------------------------------------------
   // shift_reg stays stable for the push cycle: with clk >= 6x sck the
   // next rise is several cycles away.
   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && word_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok = push_p && (!full || pop);

   // Pointer update and overflow pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push_p && full && !pop;
         if (push_ok) begin
            wr_ptr <= wr_ptr + (AW + 1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW + 1)'(1);
         end
      end
   end

   // Storage array; contents are qualified by the pointers, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= shift_reg;
      end
   end

   // No bypass: a word written this cycle becomes visible next cycle
   assign word_valid = !empty;
   assign word_data  = word_valid ? mem[rd_ptr[AW-1:0]] : '0;

`ifdef SPI_RX_STATS_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Saturating event counters for frame errors and overflows
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= 8'd0;
         ovf_count <= 8'd0;
      end else begin
         if (frame_err) begin
            err_count <= sat_inc(err_count);
         end
         if (overflow) begin
            ovf_count <= sat_inc(ovf_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx with a scoreboard queue of expected words.
// Honours SPI_RX_STATS_EN when the design is built with it.
module tb_spi_word_rx;

   localparam int WORD_W = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              sck;
   logic              sdi;
   logic              cs;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;
   logic              frame_err;
   logic              overflow;
   logic              busy;
`ifdef SPI_RX_STATS_EN
   logic [7:0]        err_count;
   logic [7:0]        ovf_count;
`endif

   int n_checks  = 0;
   int n_pass    = 0;
   int ferr_seen = 0;
   int ovf_seen  = 0;
   int pop_cnt   = 0;

   logic [WORD_W-1:0] sb_q [$];

   always #5 clk = ~clk;

   spi_word_rx #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sck        (sck),
      .sdi        (sdi),
      .cs         (cs),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .busy       (busy)
`ifdef SPI_RX_STATS_EN
      ,
      .err_count  (err_count),
      .ovf_count  (ovf_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Monitor: count pulses, compare every accepted word against the scoreboard
   always @(negedge clk) begin
      logic [WORD_W-1:0] exp;
      if (frame_err === 1'b1) ferr_seen++;
      if (overflow === 1'b1) ovf_seen++;
      if (word_valid === 1'b1 && word_ready === 1'b1) begin
         pop_cnt++;
         chk("sb_nonempty_at_pop", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            chk("pop_data", 32'(word_data), 32'(exp));
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One sck period: 4 clk low then 4 clk high, data changed while low
   task automatic send_bit(input logic b);
      sdi = b;
      sck = 1'b0;
      tick(4);
      sck = 1'b1;
      tick(4);
   endtask

   // mode 0: plain; 1: check word_valid latency; 2: pop in the FIFO write cycle
   task automatic send_word(input logic [WORD_W-1:0] w, input int mode, input bit accept);
      for (int i = WORD_W - 1; i > 0; i--) send_bit(w[i]);
      sdi = w[0];
      sck = 1'b0;
      tick(4);
      if (accept) sb_q.push_back(w);
      sck = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         if (mode == 1 && k == 3) chk("lat_not_yet", 32'(word_valid), 32'd0);
         if (mode == 1 && k == 4) chk("lat_valid", 32'(word_valid), 32'd1);
         if (mode == 2 && k == 3) word_ready = 1'b1;
         if (mode == 2 && k == 4) word_ready = 1'b0;
      end
   endtask

   task automatic frame_begin();
      sck = 1'b0;
      cs  = 1'b1;
      tick(4);
   endtask

   task automatic frame_end();
      sck = 1'b0;
      tick(4);
      cs = 1'b0;
      tick(8);
   endtask

   initial begin
      int f0;
      int o0;
      int p0;

      reset      = 1'b1;
      sck        = 1'b0;
      sdi        = 1'b0;
      cs         = 1'b0;
      word_ready = 1'b0;
      tick(3);
      chk("rst_valid", 32'(word_valid), 32'd0);
      chk("rst_data", 32'(word_data), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick(2);

      // Single word, ready high, latency check
      word_ready = 1'b1;
      f0 = ferr_seen; o0 = ovf_seen; p0 = pop_cnt;
      frame_begin();
      chk("t1_busy", 32'(busy), 32'd1);
      send_word(16'hA55A, 1, 1'b1);
      tick(1);
      chk("t1_valid_drop", 32'(word_valid), 32'd0);
      frame_end();
      chk("t1_pops", pop_cnt - p0, 1);
      chk("t1_ferr", ferr_seen - f0, 0);
      chk("t1_ovf", ovf_seen - o0, 0);
      chk("t1_busy_off", 32'(busy), 32'd0);

      // Three back-to-back words buffered, then drained one per cycle
      word_ready = 1'b0;
      frame_begin();
      send_word(16'h1234, 0, 1'b1);
      send_word(16'hBEEF, 0, 1'b1);
      send_word(16'h0001, 0, 1'b1);
      frame_end();
      chk("t2_valid_held", 32'(word_valid), 32'd1);
      chk("t2_data_head", 32'(word_data), 32'h1234);
      p0 = pop_cnt;
      word_ready = 1'b1;
      tick(1);
      chk("t2_valid_1", 32'(word_valid), 32'd1);
      tick(1);
      chk("t2_valid_2", 32'(word_valid), 32'd1);
      tick(1);
      chk("t2_valid_3", 32'(word_valid), 32'd0);
      word_ready = 1'b0;
      chk("t2_pops", pop_cnt - p0, 3);

      // Five words into a four-deep FIFO
      o0 = ovf_seen;
      frame_begin();
      send_word(16'h1111, 0, 1'b1);
      send_word(16'h2222, 0, 1'b1);
      send_word(16'h3333, 0, 1'b1);
      send_word(16'h4444, 0, 1'b1);
      send_word(16'h5555, 0, 1'b0);
      frame_end();
      chk("t3_ovf", ovf_seen - o0, 1);
`ifdef SPI_RX_STATS_EN
      chk("t3_ovf_count", 32'(ovf_count), 32'd1);
`endif
      p0 = pop_cnt;
      word_ready = 1'b1;
      tick(6);
      word_ready = 1'b0;
      chk("t3_pops", pop_cnt - p0, 4);
      chk("t3_empty", 32'(word_valid), 32'd0);

      // Nine bits then cs drop, followed by a clean word
      f0 = ferr_seen;
      frame_begin();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      frame_end();
      chk("t4_ferr", ferr_seen - f0, 1);
      chk("t4_no_word", 32'(word_valid), 32'd0);
`ifdef SPI_RX_STATS_EN
      chk("t4_err_count", 32'(err_count), 32'd1);
`endif
      word_ready = 1'b1;
      p0 = pop_cnt;
      frame_begin();
      send_word(16'h00FF, 0, 1'b1);
      frame_end();
      chk("t4_pops", pop_cnt - p0, 1);

      // sck toggling with cs low is ignored
      f0 = ferr_seen; p0 = pop_cnt;
      for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
      tick(8);
      chk("t5_no_word", 32'(word_valid), 32'd0);
      chk("t5_no_pop", pop_cnt - p0, 0);
      chk("t5_no_ferr", ferr_seen - f0, 0);
      chk("t5_busy", 32'(busy), 32'd0);
      frame_begin();
      send_word(16'h5A3C, 0, 1'b1);
      frame_end();
      chk("t5_pops", pop_cnt - p0, 1);

      // Reset mid-frame with a word already buffered
      word_ready = 1'b0;
      frame_begin();
      send_word(16'hC0DE, 0, 1'b1);
      frame_end();
      chk("t6_buffered", 32'(word_valid), 32'd1);
      frame_begin();
      for (int i = 0; i < 8; i++) send_bit(1'(i & 1));
      sck = 1'b0;
      tick(4);
      reset = 1'b1;
      tick(1);
      chk("t6_rst_valid", 32'(word_valid), 32'd0);
      chk("t6_rst_data", 32'(word_data), 32'd0);
      chk("t6_rst_ferr", 32'(frame_err), 32'd0);
      chk("t6_rst_ovf", 32'(overflow), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
`ifdef SPI_RX_STATS_EN
      chk("t6_rst_err_count", 32'(err_count), 32'd0);
      chk("t6_rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
      reset = 1'b0;
      sb_q.delete();
      f0 = ferr_seen;
      tick(6);
      chk("t6_busy_again", 32'(busy), 32'd1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      frame_end();
      chk("t6_ferr", ferr_seen - f0, 1);
      chk("t6_no_word", 32'(word_valid), 32'd0);
`ifdef SPI_RX_STATS_EN
      chk("t6_err_count", 32'(err_count), 32'd1);
`endif

      // Full FIFO with push and pop in the same cycle
      o0 = ovf_seen; p0 = pop_cnt;
      frame_begin();
      send_word(16'h0F0F, 0, 1'b1);
      send_word(16'hF0F0, 0, 1'b1);
      send_word(16'h1357, 0, 1'b1);
      send_word(16'h2468, 0, 1'b1);
      send_word(16'h9ABC, 2, 1'b1);
      frame_end();
      chk("t7_no_ovf", ovf_seen - o0, 0);
      chk("t7_one_pop", pop_cnt - p0, 1);
      chk("t7_still_valid", 32'(word_valid), 32'd1);
      word_ready = 1'b1;
      tick(6);
      word_ready = 1'b0;
      chk("t7_total_pops", pop_cnt - p0, 5);
      chk("t7_empty", 32'(word_valid), 32'd0);

      chk("sb_empty_end", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
